// File: rtl/md_sched_unit.sv
// Multiply/divide scheduler: fixed-latency busy window, HI/LO ownership,
// E-stage MFHI/MFLO read path and the MD stall request for the D stage.
module md_sched_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op_E,
  input  logic [31:0] a_E,
  input  logic [31:0] b_E,
  input  logic        md_D,
  output logic        start,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      pend_hi, pend_lo;

  logic             is_arith;
  logic             is_mul;
  logic             signed_div;
  logic [63:0]      prod_s, prod_u;
  logic [31:0]      abs_a, abs_b;
  logic [31:0]      dvd, dvs, dvs_safe;
  logic [31:0]      quo, rem;
  logic [31:0]      res_hi, res_lo;

  assign busy     = (state == BUSY);
  assign is_arith = (md_op_E >= OP_MULT) && (md_op_E <= OP_DIVU);
  assign is_mul   = (md_op_E == OP_MULT) || (md_op_E == OP_MULTU);
  assign start    = is_arith && !busy;
  assign stall_md = md_D && (start || busy);

  always_comb begin
    md_out = 32'd0;
    if (md_op_E == OP_MFHI) md_out = hi;
    else if (md_op_E == OP_MFLO) md_out = lo;
  end

  assign prod_s = $signed({{32{a_E[31]}}, a_E}) * $signed({{32{b_E[31]}}, b_E});
  assign prod_u = {32'd0, a_E} * {32'd0, b_E};

  // One unsigned divider serves both DIV and DIVU; signed results are
  // recovered by fixing the signs of the magnitude quotient/remainder.
  // 0x80000000 / -1 falls out naturally: magnitude quotient 0x80000000.
  assign signed_div = (md_op_E == OP_DIV);
  assign abs_a      = a_E[31] ? (32'd0 - a_E) : a_E;
  assign abs_b      = b_E[31] ? (32'd0 - b_E) : b_E;
  assign dvd        = signed_div ? abs_a : a_E;
  assign dvs        = signed_div ? abs_b : b_E;
  assign dvs_safe   = (dvs == 32'd0) ? 32'd1 : dvs;
  assign quo        = dvd / dvs_safe;
  assign rem        = dvd % dvs_safe;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (md_op_E)
      OP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      OP_DIV, OP_DIVU: begin
        if (b_E == 32'd0) begin
          res_hi = a_E;
          res_lo = 32'hFFFF_FFFF;
        end else if (signed_div) begin
          res_lo = (a_E[31] ^ b_E[31]) ? (32'd0 - quo) : quo;
          res_hi = a_E[31] ? (32'd0 - rem) : rem;
        end else begin
          res_lo = quo;
          res_hi = rem;
        end
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (cnt == CNT_W'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // MTHI/MTLO only land while idle; the commit edge is still BUSY, so a
  // move arriving on that edge is dropped just like one mid-operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else if (state == IDLE) begin
      if (start) begin
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        cnt     <= is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      end else if (md_op_E == OP_MTHI) begin
        hi <= a_E;
      end else if (md_op_E == OP_MTLO) begin
        lo <= a_E;
      end
    end else begin
      if (cnt == CNT_W'(1)) begin
        hi  <= pend_hi;
        lo  <= pend_lo;
        cnt <= '0;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_md_sched_unit.sv
// Directed bench for md_sched_unit: results are queued when an op is issued
// and compared against HI/LO when the busy window closes.
module tb_md_sched_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  md_op_E;
  logic [31:0] a_E, b_E;
  logic        md_D;
  logic        start, busy, stall_md;
  logic [31:0] hi, lo, md_out;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  md_sched_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .md_op_E(md_op_E), .a_E(a_E), .b_E(b_E),
    .md_D(md_D), .start(start), .busy(busy), .stall_md(stall_md),
    .hi(hi), .lo(lo), .md_out(md_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference results written from the architectural definition; returns {hi, lo}.
  function automatic logic [63:0] md_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int sa, sb;
    logic [31:0] q, r;
    md_model = 64'd0;
    sa = a;
    sb = b;
    case (op)
      4'd1: begin
        p = longint'(sa) * longint'(sb);
        md_model = p;
      end
      4'd2: md_model = {32'd0, a} * {32'd0, b};
      4'd3: begin
        if (b == 32'd0) md_model = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) md_model = {32'd0, 32'h8000_0000};
        else begin
          q = sa / sb;
          r = sa % sb;
          md_model = {r, q};
        end
      end
      4'd4: begin
        if (b == 32'd0) md_model = {a, 32'hFFFF_FFFF};
        else md_model = {a % b, a / b};
      end
      default: md_model = 64'd0;
    endcase
  endfunction

  // Issue one arithmetic op and follow it through to commit. While busy, the
  // E-stage op and operands are scrambled: either competing arithmetic ops or
  // MTHI/MTLO writes, all of which must be ignored.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic [63:0] exp,
                        input bit mt_busy, input bit d);
    int busy_cnt;
    int stall_cnt;
    logic [63:0] e;
    busy_cnt = 0;
    md_op_E = op;
    a_E = a;
    b_E = b;
    md_D = d;
    #1;
    check({tag, "_start"}, 32'(start), 32'(1));
    check({tag, "_stall_at_start"}, 32'(stall_md), 32'(d));
    exp_q.push_back(exp);
    stall_cnt = stall_md ? 1 : 0;
    step();
    for (int i = 0; i < 40 && busy; i++) begin
      busy_cnt++;
      if (stall_md) stall_cnt++;
      md_op_E = mt_busy ? 4'($urandom_range(5, 6)) : 4'($urandom_range(1, 4));
      a_E = $urandom;
      b_E = $urandom;
      #1;
      if (i == 0) check({tag, "_no_start_while_busy"}, 32'(start), 32'(0));
      step();
    end
    md_op_E = 4'd0;
    #1;
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(n));
    check({tag, "_stall_cycles"}, 32'(stall_cnt), d ? 32'(n + 1) : 32'(0));
    check({tag, "_stall_after"}, 32'(stall_md), 32'(0));
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_hi"}, hi, e[63:32]);
      check({tag, "_lo"}, lo, e[31:0]);
    end
    md_D = 1'b0;
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    reset = 1'b0;
    md_op_E = 4'd0;
    a_E = 32'd0;
    b_E = 32'd0;
    md_D = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    reset = 1'b1;
    step();

    // Asynchronous reset with no clock edge.
    md_op_E = 4'd5;
    a_E = 32'h5555_AAAA;
    step();
    md_op_E = 4'd6;
    a_E = 32'h1234_5678;
    step();
    md_op_E = 4'd0;
    check("mthi_idle", hi, 32'h5555_AAAA);
    check("mtlo_idle", lo, 32'h1234_5678);
    #2 reset = 1'b0;
    #1;
    check("async_reset_hi", hi, 32'd0);
    check("async_reset_lo", lo, 32'd0);
    check("async_reset_busy", 32'(busy), 32'(0));
    step();
    check("reset_hold_hi", hi, 32'd0);
    check("reset_hold_lo", lo, 32'd0);
    reset = 1'b1;
    step();

    md_D = 1'b1;
    #1;
    check("stall_idle_no_op", 32'(stall_md), 32'(0));

    run_op("mult_neg", 4'd1, 32'hFFFF_FFF9, 32'd3, MC, {32'hFFFF_FFFF, 32'hFFFF_FFEB}, 1'b0, 1'b1);
    run_op("divu", 4'd4, 32'd100, 32'd7, DC, {32'd2, 32'd14}, 1'b0, 1'b0);
    run_op("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, DC, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, 1'b1);
    run_op("div_zero", 4'd3, 32'h0000_1234, 32'd0, DC, {32'h0000_1234, 32'hFFFF_FFFF}, 1'b0, 1'b0);
    run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, DC, {32'd0, 32'h8000_0000}, 1'b0, 1'b0);

    // MTHI then MFHI/MFLO read path.
    md_op_E = 4'd5;
    a_E = 32'hCAFE_BABE;
    step();
    md_op_E = 4'd7;
    #1;
    check("mfhi_md_out", md_out, 32'hCAFE_BABE);
    md_op_E = 4'd8;
    #1;
    check("mflo_md_out", md_out, 32'h8000_0000);
    md_op_E = 4'd0;
    #1;
    check("md_out_none", md_out, 32'd0);

    run_op("multu_mt_busy", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MC,
           md_model(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 1'b1, 1'b0);

    for (int k = 0; k < 6; k++) begin
      rop = 4'($urandom_range(1, 4));
      ra = $urandom;
      rb = (k == 3) ? 32'd0 : ((k == 4) ? 32'($urandom_range(1, 300)) : $urandom);
      run_op("rand", rop, ra, rb, (rop <= 4'd2) ? MC : DC, md_model(rop, ra, rb), k[0], k[1]);
    end

    // Reset mid-operation discards the pending result.
    md_op_E = 4'd2;
    a_E = 32'h0001_0000;
    b_E = 32'h0001_0000;
    step();
    md_op_E = 4'd0;
    step();
    step();
    check("mid_op_busy_before_reset", 32'(busy), 32'(1));
    #2 reset = 1'b0;
    #1;
    check("mid_op_reset_busy", 32'(busy), 32'(0));
    check("mid_op_reset_hi", hi, 32'd0);
    check("mid_op_reset_lo", lo, 32'd0);
    step();
    reset = 1'b1;
    repeat (12) step();
    check("no_commit_busy", 32'(busy), 32'(0));
    check("no_commit_hi", hi, 32'd0);
    check("no_commit_lo", lo, 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
